// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding (common with the receiver), oversampling
// ratio, default frame parameters and the even-parity helper.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int OVERSAMPLE      = 16;
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_PARITY = PARITY,
    ST_STOP   = STOP
  } state_t;

  // Even parity over the low nbits of d.
  function automatic logic even_parity(input logic [7:0] d, input int nbits);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) begin
        p = p ^ d[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity bit
// (define UART_TX_PARITY_EN), SB_TICK-tick stop period, paced by a 16x s_tick enable.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       tx_busy,
  output logic       tx
);

  localparam int SW = $clog2(SB_TICK + 1);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [7:0]      b_q, b_d;
  logic            tx_q, tx_d;
  logic            done_s;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_s  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d = ST_START;
          s_d     = '0;
          n_d     = 3'd0;
          b_d     = din;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(din, DBIT);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (s_tick && (s_q == S_BIT_LAST)) begin
          state_d = ST_DATA;
          s_d     = '0;
          n_d     = 3'd0;
        end else if (s_tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
      ST_DATA: begin
        if (s_tick && (s_q == S_BIT_LAST)) begin
          s_d = '0;
          b_d = {1'b0, b_q[7:1]};
          if (n_q == N_LAST) begin
            n_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            n_d = n_q + 3'd1;
          end
        end else if (s_tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick && (s_q == S_BIT_LAST)) begin
          state_d = ST_STOP;
          s_d     = '0;
        end else if (s_tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
`endif
      ST_STOP: begin
        if (s_tick && (s_q == S_STOP_LAST)) begin
          state_d = ST_IDLE;
          s_d     = '0;
          done_s  = 1'b1;
        end else if (s_tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        n_d     = 3'd0;
      end
    endcase
  end

  // Line level follows the state being entered, so tx moves on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= 3'd0;
      b_q     <= 8'd0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_done_tick = done_s;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape and timing, ignored requests, mid-frame reset,
// back-to-back bytes decoded by a mid-bit sampling receiver, and a 2-stop-bit instance.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_start_a = 1'b0;
  logic       tx_start_b = 1'b0;
  logic [7:0] din = 8'h00;
  logic       done_a, busy_a, tx_a;
  logic       done_b, busy_b, tx_b;

  int vecs = 0;
  int errs = 0;
  int div_cnt = 0;
  int dones_a = 0;
  int dones_b = 0;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut_a (
    .clk(clk), .reset(reset), .tx_start(tx_start_a), .s_tick(s_tick), .din(din),
    .tx_done_tick(done_a), .tx_busy(busy_a), .tx(tx_a));

  uart_tx #(.DBIT(8), .SB_TICK(32)) dut_b (
    .clk(clk), .reset(reset), .tx_start(tx_start_b), .s_tick(s_tick), .din(din),
    .tx_done_tick(done_b), .tx_busy(busy_b), .tx(tx_b));

  // One clock: s_tick every 16th clk, done pulses counted before the edge.
  task automatic step();
    s_tick = (div_cnt == 15);
    div_cnt = (div_cnt + 1) % 16;
    #1;
    if (done_a === 1'b1) dones_a++;
    if (done_b === 1'b1) dones_b++;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send byte b on instance sel (0: 1 stop bit, 1: 2 stop bits); inj_at >= 0 raises a
  // stray tx_start with din=0x3C while the tick count equals inj_at.
  task automatic send_frame(input bit sel, input logic [7:0] b, input int inj_at);
    int sb;
    int frame;
    int c;
    int d0;
    int budget;
    int w;
    logic [7:0] rx;
    logic exp_bit;
    logic line;
    sb     = sel ? 32 : 16;
    frame  = 16 + 16 * 8 + 16 * PAR + sb;
    c      = 0;
    budget = 0;
    rx     = 8'h00;
    din    = b;
    d0     = sel ? dones_b : dones_a;
    if (sel) tx_start_b = 1'b1; else tx_start_a = 1'b1;
    step();
    tx_start_a = 1'b0;
    tx_start_b = 1'b0;
    check("start_edge", {31'd0, sel ? tx_b : tx_a}, 32'd0);
    check("busy_on", {31'd0, sel ? busy_b : busy_a}, 32'd1);
    while (((sel ? dones_b : dones_a) == d0) && (budget < 16 * frame + 64)) begin
      if (c == inj_at) begin
        din = 8'h3C;
        if (sel) tx_start_b = 1'b1; else tx_start_a = 1'b1;
      end
      step();
      budget++;
      tx_start_a = 1'b0;
      tx_start_b = 1'b0;
      if (s_tick) begin
        c++;
        if ((c % 16 == 8) && (c < frame)) begin
          w    = c / 16;
          line = sel ? tx_b : tx_a;
          if (w == 0) exp_bit = 1'b0;
          else if (w <= 8) exp_bit = b[w-1];
          else if ((PAR == 1) && (w == 9)) exp_bit = ^b;
          else exp_bit = 1'b1;
          if ((w >= 1) && (w <= 8)) rx[w-1] = line;
          check($sformatf("bit%0d_of_%02h", w, b), {31'd0, line}, {31'd0, exp_bit});
          check("busy_mid", {31'd0, sel ? busy_b : busy_a}, 32'd1);
        end
      end
    end
    check("done_count", (sel ? dones_b : dones_a) - d0, 32'd1);
    check("frame_ticks", c, frame);
    check("rx_byte", {24'd0, rx}, {24'd0, b});
    check("tx_idle_after", {31'd0, sel ? tx_b : tx_a}, 32'd1);
    check("busy_off", {31'd0, sel ? busy_b : busy_a}, 32'd0);
  endtask

  initial begin
    int c;
    int d0;
    int budget;
    logic tx_min;
    logic [7:0] bytes [4];
    bytes = '{8'h00, 8'hFF, 8'h55, 8'h81};

    // Reset state.
    reset = 1'b1;
    repeat (3) step();
    check("rst_tx_a", {31'd0, tx_a}, 32'd1);
    check("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check("rst_done_a", {31'd0, done_a}, 32'd0);
    check("rst_tx_b", {31'd0, tx_b}, 32'd1);
    reset = 1'b0;
    repeat (5) step();
    check("idle_tx", {31'd0, tx_a}, 32'd1);

    // 0xA5 frame with a stray request mid-data, then confirm no second frame follows.
    send_frame(1'b0, 8'hA5, 40);
    d0 = dones_a;
    tx_min = 1'b1;
    repeat (300) begin
      step();
      tx_min = tx_min & tx_a;
    end
    check("no_second_done", dones_a, d0);
    check("no_second_frame", {31'd0, tx_min}, 32'd1);
    check("still_idle", {31'd0, busy_a}, 32'd0);

    // Reset during data bit 3 of a 0x00 frame.
    din = 8'h00;
    tx_start_a = 1'b1;
    step();
    tx_start_a = 1'b0;
    c = 0;
    budget = 0;
    while ((c < 16 + 16 * 3 + 8) && (budget < 2000)) begin
      step();
      budget++;
      if (s_tick) c++;
    end
    check("abort_reached_bit3", c, 32'd72);
    check("abort_line_low", {31'd0, tx_a}, 32'd0);
    d0 = dones_a;
    reset = 1'b1;
    step();
    check("abort_tx", {31'd0, tx_a}, 32'd1);
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_no_done", dones_a, d0);
    reset = 1'b0;
    step();
    send_frame(1'b0, 8'h5A, -1);

    // Back-to-back bytes, each request issued the clk after the previous done pulse.
    for (int i = 0; i < 4; i++) begin
      send_frame(1'b0, bytes[i], -1);
    end

    // Two stop bits: 176-tick frame.
    send_frame(1'b1, 8'hC3, -1);

`ifdef UART_TX_PARITY_EN
    send_frame(1'b0, 8'h07, -1);
    send_frame(1'b0, 8'h03, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
